load_store_unit: RTL and testbench

Sequential load/store controller between the execute stage and the unified memory's data port. It accepts one RV64 load or store per request, checks alignment and range, and sequences word-wide memory cycles: single read for loads, one or two writes for stores, read-modify-write for byte/halfword stores. It returns sign/zero-extended load data or an error flag.

---
 rtl/load_store_unit.sv | 187 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store controller: sequences RV64 loads and stores onto a 32-bit-word memory port,
// with alignment/range checks and read-modify-write for byte/halfword stores.
module load_store_unit #(
    parameter int MEM_WORDS = 264192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [63:0] resp_rdata,
    output logic        mem_wr,
    output logic [29:0] mem_daddr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WR_LO, WR_HI, DONE} state_t;

    state_t      state_q, state_d;
    logic        store_q, store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [63:0] resp_rdata_q, resp_rdata_d;
    logic        mem_wr_q, mem_wr_d;
    logic [29:0] mem_daddr_q, mem_daddr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;

    logic        misaligned, bad_funct3, out_of_range, req_err;
    logic [30:0] last_word;
    logic [4:0]  bit_off;
    logic [31:0] lo_shifted, lane_mask, lane_data, merged_word;
    logic [63:0] load_result;

    // Request checks act on the live request inputs so an error can go straight to DONE.
    always_comb begin
        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            2'b11:   misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
        bad_funct3   = (req_funct3 == 3'b111) || (req_store && req_funct3[2]);
        last_word    = {1'b0, req_addr[31:2]} + {30'b0, req_funct3 == 3'b011};
        out_of_range = last_word >= 31'(MEM_WORDS);
        req_err      = misaligned || bad_funct3 || out_of_range;
    end

    always_comb begin
        bit_off    = {addr_q[1:0], 3'b000};
        lo_shifted = mem_rdata[31:0] >> bit_off;
        case (funct3_q)
            3'b000:  load_result = {{56{lo_shifted[7]}}, lo_shifted[7:0]};
            3'b001:  load_result = {{48{lo_shifted[15]}}, lo_shifted[15:0]};
            3'b010:  load_result = {{32{lo_shifted[31]}}, lo_shifted};
            3'b011:  load_result = mem_rdata;
            3'b100:  load_result = {56'b0, lo_shifted[7:0]};
            3'b101:  load_result = {48'b0, lo_shifted[15:0]};
            3'b110:  load_result = {32'b0, lo_shifted};
            default: load_result = '0;
        endcase
        lane_mask   = (funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << bit_off;
        lane_data   = wdata_q[31:0] << bit_off;
        merged_word = (mem_rdata[31:0] & ~lane_mask) | (lane_data & lane_mask);
    end

    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (req_valid && ready_q) begin
                    store_d  = req_store;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (req_err) begin
                        state_d      = DONE;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else if (!req_store) begin
                        state_d = LOAD;
                    end else if (!req_funct3[1]) begin
                        state_d = RMW_RD;
                    end else begin
                        state_d = WR_LO;
                    end
                end
            end
            LOAD: begin
                state_d      = DONE;
                resp_err_d   = 1'b0;
                resp_rdata_d = load_result;
            end
            RMW_RD: begin
                wdata_d[31:0] = merged_word;
                state_d       = WR_LO;
            end
            WR_LO: begin
                if (store_q && funct3_q == 3'b011) begin
                    state_d = WR_HI;
                end else begin
                    state_d      = DONE;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                end
            end
            WR_HI: begin
                state_d      = DONE;
                resp_err_d   = 1'b0;
                resp_rdata_d = '0;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they leave the flops already settled.
        ready_d      = (state_d == IDLE) || (state_d == DONE);
        resp_valid_d = (state_d == DONE);
        mem_wr_d     = (state_d == WR_LO) || (state_d == WR_HI);
        mem_daddr_d  = mem_daddr_q;
        mem_wdata_d  = '0;
        case (state_d)
            LOAD, RMW_RD: mem_daddr_d = addr_d[31:2];
            WR_LO: begin
                mem_daddr_d = addr_d[31:2];
                mem_wdata_d = {32'b0, wdata_d[31:0]};
            end
            WR_HI: begin
                mem_daddr_d = addr_d[31:2] + 30'd1;
                mem_wdata_d = {32'b0, wdata_d[63:32]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            store_q      <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_wr_q     <= 1'b0;
            mem_daddr_q  <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            store_q      <= store_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_wr_q     <= mem_wr_d;
            mem_daddr_q  <= mem_daddr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_wr     = mem_wr_q;
    assign mem_daddr  = mem_daddr_q;
    assign mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-abort sequence and random
// requests checked against a byte-level memory model.
module tb_load_store_unit;
    localparam int MEM_WORDS = 264192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_wr;
    logic [63:0] resp_rdata, mem_wdata, mem_rdata;
    logic [29:0] mem_daddr, daddr_p1;

    logic [31:0] mem     [0:MEM_WORDS-1] = '{default: 32'h0};
    logic [31:0] ref_mem [0:MEM_WORDS-1] = '{default: 32'h0};
    logic        poke_en = 1'b0;
    logic [29:0] poke_addr = '0;
    logic [31:0] poke_data = '0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [29:0] wr_addrs [0:3];

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_wr(mem_wr), .mem_daddr(mem_daddr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign daddr_p1 = mem_daddr + 30'd1;
    assign mem_rdata[31:0]  = (int'(mem_daddr) < MEM_WORDS) ? mem[mem_daddr] : 32'h0;
    assign mem_rdata[63:32] = (int'(daddr_p1) < MEM_WORDS) ? mem[daddr_p1] : 32'h0;

    always @(negedge clk) begin
        if (poke_en)
            mem[poke_addr] <= poke_data;
        else if (mem_wr && int'(mem_daddr) < MEM_WORDS)
            mem[mem_daddr] <= mem_wdata[31:0];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic poke(input int w, input logic [31:0] d);
        poke_en = 1'b1;
        poke_addr = 30'(w);
        poke_data = d;
        ref_mem[w] = d;
        @(negedge clk);
        #1 poke_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Reference: byte-by-byte access over the word array, errors from the alignment/range rules.
    task automatic model_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [63:0] wd, output logic e, output logic [63:0] rd,
                             output int lat, output int nwr);
        int size;
        longint word;
        logic [31:0] ba;
        size = 1 << f3[1:0];
        word = longint'(a) / 4;
        e = (f3 == 3'd7) || (st && f3 >= 3'd4) || ((int'(a[2:0]) % size) != 0) ||
            ((word + ((size == 8) ? 1 : 0)) >= longint'(MEM_WORDS));
        rd = '0;
        lat = 0;
        nwr = 0;
        if (e) return;
        for (int i = 0; i < size; i++) begin
            ba = a + 32'(i);
            if (st) ref_mem[ba[31:2]][{ba[1:0], 3'b000} +: 8] = wd[8*i +: 8];
            else    rd[8*i +: 8] = ref_mem[ba[31:2]][{ba[1:0], 3'b000} +: 8];
        end
        if (st) begin
            lat = (size == 4) ? 1 : 2;
            nwr = (size == 8) ? 2 : 1;
        end else begin
            lat = 1;
            if (!f3[2] && size < 8 && rd[8*size-1]) rd = rd | (~64'h0 << (8*size));
        end
    endtask

    task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [63:0] wd, output logic e, output logic [63:0] rd,
                          output int lat, output int nwr);
        int waitc = 0;
        while (!req_ready && waitc < 20) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        check("req_ready_before_req", {63'b0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_store = st;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        nwr = 0;
        while (!resp_valid && lat < 10) begin
            if (mem_wr) begin
                if (nwr < 4) wr_addrs[nwr] = mem_daddr;
                nwr++;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        if (!resp_valid) check("resp_timeout", {63'b0, resp_valid}, 64'd1);
        e = resp_err;
        rd = resp_rdata;
        $display("txn st=%0d f3=%0d addr=0x%08h wdata=0x%016h -> err=%0d rdata=0x%016h lat=%0d wr=%0d",
                 st, f3, a, wd, e, rd, lat, nwr);
    endtask

    typedef struct {
        bit          st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [63:0] wd;
        logic        err;
        logic [63:0] rd;
        int          lat;
        int          nwr;
        string       name;
    } vec_t;

    vec_t vecs [0:15];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e, me;
        logic [63:0] rd, mrd;
        int          lat, nwr, mlat, mnwr;
        bit          st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [63:0] wd;

        vecs[0]  = '{0, 3'b000, 32'h13, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFDE, 1, 0, "LB_13"};
        vecs[1]  = '{0, 3'b100, 32'h13, 64'h0, 1'b0, 64'h0000_0000_0000_00DE, 1, 0, "LBU_13"};
        vecs[2]  = '{0, 3'b011, 32'h10, 64'h0, 1'b0, 64'h0123_4567_DEAD_BEEF, 1, 0, "LD_10"};
        vecs[3]  = '{0, 3'b110, 32'h14, 64'h0, 1'b0, 64'h0000_0000_0123_4567, 1, 0, "LWU_14"};
        vecs[4]  = '{1, 3'b000, 32'h11, 64'h55, 1'b0, 64'h0, 2, 1, "SB_11"};
        vecs[5]  = '{0, 3'b010, 32'h10, 64'h0, 1'b0, 64'hFFFF_FFFF_DEAD_55EF, 1, 0, "LW_10"};
        vecs[6]  = '{1, 3'b011, 32'h18, 64'h1122_3344_5566_7788, 1'b0, 64'h0, 2, 2, "SD_18"};
        vecs[7]  = '{0, 3'b001, 32'h11, 64'h0, 1'b1, 64'h0, 0, 0, "LH_11_misalign"};
        vecs[8]  = '{1, 3'b011, 32'h14, 64'hFFFF, 1'b1, 64'h0, 0, 0, "SD_14_misalign"};
        vecs[9]  = '{1, 3'b100, 32'h20, 64'h77, 1'b1, 64'h0, 0, 0, "store_f3_100"};
        vecs[10] = '{0, 3'b010, 32'h0010_2000, 64'h0, 1'b1, 64'h0, 0, 0, "LW_range"};
        vecs[11] = '{1, 3'b010, 32'h0010_1FFC, 64'hABCD_0000_8000_0001, 1'b0, 64'h0, 1, 1, "SW_last"};
        vecs[12] = '{0, 3'b010, 32'h0010_1FFC, 64'h0, 1'b0, 64'hFFFF_FFFF_8000_0001, 1, 0, "LW_last"};
        vecs[13] = '{0, 3'b011, 32'h0010_1FF8, 64'h0, 1'b0, 64'h8000_0001_0000_0000, 1, 0, "LD_last"};
        vecs[14] = '{0, 3'b011, 32'h0010_2000, 64'h0, 1'b1, 64'h0, 0, 0, "LD_range"};
        vecs[15] = '{0, 3'b111, 32'h10, 64'h0, 1'b1, 64'h0, 0, 0, "f3_111"};

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {63'b0, req_ready}, 64'd1);
        check("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
        check("rst_resp_err", {63'b0, resp_err}, 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_mem_wr", {63'b0, mem_wr}, 64'd0);
        check("rst_mem_daddr", {34'b0, mem_daddr}, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        rst = 1'b0;

        poke(4, 32'hDEAD_BEEF);
        poke(5, 32'h0123_4567);

        foreach (vecs[i]) begin
            model_req(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wd, me, mrd, mlat, mnwr);
            do_req(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wd, e, rd, lat, nwr);
            check({vecs[i].name, "_err"}, {63'b0, e}, {63'b0, vecs[i].err});
            check({vecs[i].name, "_rdata"}, rd, vecs[i].rd);
            check({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].lat));
            check({vecs[i].name, "_wr_cycles"}, 64'(nwr), 64'(vecs[i].nwr));
            if (i == 6) begin
                check("SD_18_wr0_addr", {34'b0, wr_addrs[0]}, 64'd6);
                check("SD_18_wr1_addr", {34'b0, wr_addrs[1]}, 64'd7);
            end
        end
        check("mem4_after_SB", {32'b0, mem[4]}, 64'hDEAD_55EF);
        check("mem6_after_SD", {32'b0, mem[6]}, 64'h5566_7788);
        check("mem7_after_SD", {32'b0, mem[7]}, 64'h1122_3344);

        // A request held while the unit is busy must not be latched.
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b110; req_addr = 32'h14; req_wdata = '0;
        @(posedge clk);
        #1;
        req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 64'h9999_9999;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("busy_ignore_resp_valid", {63'b0, resp_valid}, 64'd1);
        check("busy_ignore_rdata", resp_rdata, 64'h0000_0000_0123_4567);
        @(posedge clk);
        #1;
        check("busy_ignore_no_mem_wr", {63'b0, mem_wr}, 64'd0);
        check("busy_ignore_mem4", {32'b0, mem[4]}, 64'hDEAD_55EF);

        // Reset landing in the second SD write cycle.
        poke(6, 32'hAAAA_AAAA);
        poke(7, 32'hBBBB_BBBB);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b011; req_addr = 32'h18;
        req_wdata = 64'h0102_0304_0506_0708;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("abort_wrlo_daddr", {33'b0, mem_wr, mem_daddr}, {33'b0, 1'b1, 30'd6});
        @(posedge clk);
        #1;
        check("abort_wrhi_daddr", {33'b0, mem_wr, mem_daddr}, {33'b0, 1'b1, 30'd7});
        rst = 1'b1;
        #1;
        check("abort_mem_wr_async", {63'b0, mem_wr}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_req_ready", {63'b0, req_ready}, 64'd1);
        check("abort_no_resp", {63'b0, resp_valid}, 64'd0);
        check("abort_mem6", {32'b0, mem[6]}, 64'h0506_0708);
        check("abort_mem7", {32'b0, mem[7]}, 64'hBBBB_BBBB);
        ref_mem[6] = 32'h0506_0708;
        do_req(1'b0, 3'b010, 32'h1C, 64'h0, e, rd, lat, nwr);
        check("abort_LW_1C_err", {63'b0, e}, 64'd0);
        check("abort_LW_1C_rdata", rd, 64'hFFFF_FFFF_BBBB_BBBB);

        for (int n = 0; n < 300; n++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = 32'(4 * MEM_WORDS - 16) + 32'($urandom_range(0, 31));
            else                           a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
            wd = {$urandom, $urandom};
            model_req(st, f3, a, wd, me, mrd, mlat, mnwr);
            do_req(st, f3, a, wd, e, rd, lat, nwr);
            check($sformatf("rand%0d_err", n), {63'b0, e}, {63'b0, me});
            check($sformatf("rand%0d_rdata", n), rd, mrd);
            check($sformatf("rand%0d_latency", n), 64'(lat), 64'(mlat));
            check($sformatf("rand%0d_wr_cycles", n), 64'(nwr), 64'(mnwr));
        end
        @(posedge clk);
        #1;
        for (int w = 0; w < 72; w++)
            check($sformatf("final_mem%0d", w), {32'b0, mem[w]}, {32'b0, ref_mem[w]});
        for (int w = MEM_WORDS - 8; w < MEM_WORDS; w++)
            check($sformatf("final_mem%0d", w), {32'b0, mem[w]}, {32'b0, ref_mem[w]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
